sbox_iter_ctrl: RTL and testbench

- Sequencer for the masked S-box round loop: the share-wise input mux, the masked S-box pipeline, and the clock-gated state register.
- Accepts a job over a valid/ready handshake and drives the mux select (fresh input vs. feedback).
- Holds fresh-randomness enable while the HPC3 pipeline settles, and pulses the state-register clock-gate enable once per iteration.
- Signals completion after the programmed number of S-box iterations. Control only; it never touches share data.

---
 rtl/sbox_iter_ctrl_if.sv | 33 +++
 rtl/sbox_iter_ctrl.sv | 129 ++++++++++++
 tb/tb_sbox_iter_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sbox_iter_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : sbox_iter_ctrl_if
// Brief   : Job handshake and round-loop control bundle for sbox_iter_ctrl.
// Rev     : 1.0  initial release
// ============================================================================
interface sbox_iter_ctrl_if #(
    parameter int ITER_W = 4
);
    logic              start_valid;
    logic              start_ready;
    logic [ITER_W-1:0] iter_count;
    logic              abort;
    logic              sel_load;
    logic              fresh_en;
    logic              reg_en;
    logic              busy;
    logic              done;
    logic [ITER_W-1:0] iter_left;

    // Job source side.
    modport master (
        output start_valid, iter_count, abort,
        input  start_ready, sel_load, fresh_en, reg_en, busy, done, iter_left
    );

    // Sequencer side.
    modport slave (
        input  start_valid, iter_count, abort,
        output start_ready, sel_load, fresh_en, reg_en, busy, done, iter_left
    );
endinterface
`default_nettype wire

// File: rtl/sbox_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : sbox_iter_ctrl
// Brief   : Round-loop sequencer for the masked S-box: mux select, fresh
//           randomness enable, state-register gate pulse and completion.
// Rev     : 1.0  initial release
// ============================================================================
module sbox_iter_ctrl #(
    parameter int SBOX_LATENCY = 4,
    parameter int CNT_W        = 3,
    parameter int ITER_W       = 4
) (
    input  logic            clk,
    input  logic            rst,
    sbox_iter_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_CAPT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]  c_lat_reload = CNT_W'(SBOX_LATENCY - 1);
    localparam logic [CNT_W-1:0]  c_lat_one    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  c_lat_zero   = '0;
    localparam logic [ITER_W-1:0] c_iter_one   = ITER_W'(1);
    localparam logic [ITER_W-1:0] c_iter_zero  = '0;

    state_t            r_state;
    logic [CNT_W-1:0]  r_lat_cnt;
    logic [ITER_W-1:0] r_iter_left;
    logic              r_first;

    state_t            w_state_nxt;
    logic [CNT_W-1:0]  w_lat_cnt_nxt;
    logic [ITER_W-1:0] w_iter_left_nxt;
    logic              w_first_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_lat_cnt   <= c_lat_zero;
            r_iter_left <= c_iter_zero;
            r_first     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_lat_cnt   <= w_lat_cnt_nxt;
            r_iter_left <= w_iter_left_nxt;
            r_first     <= w_first_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_lat_cnt_nxt   = r_lat_cnt;
        w_iter_left_nxt = r_iter_left;
        w_first_nxt     = r_first;

        case (r_state)
            S_IDLE: begin
                // abort is deliberately ignored here so a coincident request wins.
                if (bus.start_valid) begin
                    w_iter_left_nxt = bus.iter_count;
                    w_first_nxt     = 1'b1;
                    if (bus.iter_count == c_iter_zero) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt   = S_RUN;
                        w_lat_cnt_nxt = c_lat_reload;
                    end
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    w_state_nxt     = S_IDLE;
                    w_iter_left_nxt = c_iter_zero;
                    w_first_nxt     = 1'b0;
                end else if (r_lat_cnt == c_lat_zero) begin
                    w_state_nxt = S_CAPT;
                end else begin
                    w_lat_cnt_nxt = r_lat_cnt - c_lat_one;
                end
            end
            S_CAPT: begin
                w_first_nxt = 1'b0;
                if (bus.abort) begin
                    w_state_nxt     = S_IDLE;
                    w_iter_left_nxt = c_iter_zero;
                end else begin
                    // Guarded so a corrupted count can never wrap to all-ones.
                    if (r_iter_left != c_iter_zero) begin
                        w_iter_left_nxt = r_iter_left - c_iter_one;
                    end
                    if (r_iter_left <= c_iter_one) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt   = S_RUN;
                        w_lat_cnt_nxt = c_lat_reload;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_first_nxt = 1'b0;
                if (bus.abort) begin
                    w_iter_left_nxt = c_iter_zero;
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_iter_left_nxt = c_iter_zero;
                w_first_nxt     = 1'b0;
            end
        endcase
    end

    // Everything but start_ready is decoded purely from registered state.
    assign bus.start_ready = (r_state == S_IDLE) && !rst;
    assign bus.fresh_en    = (r_state == S_RUN);
    assign bus.reg_en      = (r_state == S_CAPT);
    assign bus.sel_load    = r_first && ((r_state == S_RUN) || (r_state == S_CAPT));
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = (r_state == S_DONE);
    assign bus.iter_left   = r_iter_left;

endmodule
`default_nettype wire

// File: tb/tb_sbox_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_sbox_iter_ctrl
// Brief   : Scoreboard bench for sbox_iter_ctrl with a timeline reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_sbox_iter_ctrl;

    localparam int L      = 4;
    localparam int CNT_W  = 3;
    localparam int ITER_W = 4;
    localparam int PER    = 10;

    typedef struct {
        bit is_done;
        int cyc;
        int il;
        bit sel;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_fresh = 0, exp_busy = 0, exp_reg = 0, exp_done = 0;
    int act_fresh = 0, act_busy = 0, act_reg = 0, act_done = 0;
    ev_t evq[$];

    sbox_iter_ctrl_if #(.ITER_W(ITER_W)) bus ();

    sbox_iter_ctrl #(
        .SBOX_LATENCY(L),
        .CNT_W       (CNT_W),
        .ITER_W      (ITER_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #(PER/2) clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #(PER * 20000);
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    task automatic chk(input string name, input longint got, input longint expv);
        n_cmp++;
        if (got != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    // Cycles at offset x from the first post-handshake cycle: iteration x/(L+1),
    // RUN when x%(L+1) < L, CAPT otherwise, DONE at offset n*(L+1).
    function automatic int run_cycles(input int n, input int last);
        int c = 0;
        for (int x = 0; x <= last; x++)
            if ((x / (L + 1)) < n && (x % (L + 1)) < L) c++;
        return c;
    endfunction

    task automatic push_events(input int h, input int n, input int last);
        ev_t e;
        for (int k = 1; k <= n; k++) begin
            if (k * (L + 1) - 1 <= last) begin
                e.is_done = 1'b0;
                e.cyc     = h + k * (L + 1) - 1;
                e.il      = n - k + 1;
                e.sel     = (k == 1);
                evq.push_back(e);
                exp_reg++;
            end
        end
        if (n * (L + 1) <= last) begin
            e.is_done = 1'b1;
            e.cyc     = h + n * (L + 1);
            e.il      = 0;
            e.sel     = 1'b0;
            evq.push_back(e);
            exp_done++;
        end
        exp_fresh += run_cycles(n, last);
        exp_busy  += last + 1;
    endtask

    // Monitor: pops the scoreboard whenever a capture or completion shows up.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("reset_outputs",
                    {bus.start_ready, bus.sel_load, bus.fresh_en, bus.reg_en,
                     bus.busy, bus.done, bus.iter_left}, 0);
            end else begin
                chk("ready_vs_busy", bus.start_ready, !bus.busy);
                if (bus.fresh_en) act_fresh++;
                if (bus.busy)     act_busy++;
                if (bus.reg_en)   act_reg++;
                if (bus.done)     act_done++;
                if (bus.reg_en && (bus.done || bus.fresh_en))
                    chk("reg_en_overlap", {bus.done, bus.fresh_en}, 0);
                if (bus.reg_en || bus.done) begin
                    if (evq.size() == 0) begin
                        chk("unexpected_event", {bus.reg_en, bus.done}, 0);
                    end else begin
                        e = evq.pop_front();
                        chk("ev_kind", bus.done, e.is_done);
                        chk("ev_cycle", cyc, e.cyc);
                        chk("ev_iter_left", bus.iter_left, e.il);
                        if (!e.is_done) chk("ev_sel_load", bus.sel_load, e.sel);
                    end
                end
            end
        end
    end

    // Call at a negedge; returns at the negedge of the DONE cycle, or of the
    // IDLE cycle after an abort.
    task automatic run_job(input int n, input int abort_off, input bit hold);
        int h, last, w;
        bus.start_valid = 1'b1;
        bus.iter_count  = ITER_W'(n);
        w = 0;
        while (!bus.start_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!bus.start_ready) begin
            chk("handshake_timeout", 0, 1);
            bus.start_valid = 1'b0;
            return;
        end
        h    = cyc + 1;
        last = (abort_off >= 0) ? abort_off : n * (L + 1);
        push_events(h, n, last);
        @(negedge clk);
        bus.start_valid = hold;
        bus.abort       = 1'b0;
        if (abort_off >= 0) begin
            while (cyc < h + abort_off) @(negedge clk);
            bus.abort = 1'b1;
            @(negedge clk);
            bus.abort = 1'b0;
            chk("abort_ready", bus.start_ready, 1);
            chk("abort_iter_left", bus.iter_left, 0);
            chk("abort_busy", bus.busy, 0);
            chk("abort_no_done", bus.done, 0);
        end else begin
            while (cyc < h + last) @(negedge clk);
        end
    endtask

    initial begin
        int h, roff, n, ab, gap, gap_next;
        bus.start_valid = 1'b0;
        bus.iter_count  = '0;
        bus.abort       = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset_ready_low", bus.start_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", bus.start_ready, 1);
        chk("post_reset_busy", bus.busy, 0);
        chk("post_reset_iter_left", bus.iter_left, 0);

        run_job(1, -1, 1'b0);
        repeat (2) @(negedge clk);
        run_job(3, -1, 1'b0);
        repeat (2) @(negedge clk);
        run_job(0, -1, 1'b0);
        repeat (2) @(negedge clk);
        run_job(4, L + 2, 1'b0);
        repeat (2) @(negedge clk);
        run_job(3, 2 * (L + 1) - 1, 1'b0);
        repeat (2) @(negedge clk);
        run_job(15, -1, 1'b0);
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of the second iteration's RUN phase.
        bus.start_valid = 1'b1;
        bus.iter_count  = ITER_W'(3);
        while (!bus.start_ready) @(negedge clk);
        h    = cyc + 1;
        roff = L + 1 + 2;
        push_events(h, 3, roff - 1);
        @(negedge clk);
        bus.start_valid = 1'b0;
        while (cyc < h + roff - 1) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_outputs",
            {bus.start_ready, bus.sel_load, bus.fresh_en, bus.reg_en,
             bus.busy, bus.done, bus.iter_left}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_release_ready", bus.start_ready, 1);
        repeat (2) @(negedge clk);
        run_job(2, -1, 1'b0);

        // Back-to-back with start_valid held through DONE.
        repeat (2) @(negedge clk);
        run_job(2, -1, 1'b1);
        run_job(2, -1, 1'b0);

        gap_next = $urandom_range(0, 3);
        for (int j = 0; j < 40; j++) begin
            gap      = gap_next;
            gap_next = (j == 39) ? 1 : $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                bus.abort = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            n  = ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 6);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n * (L + 1)) : -1;
            run_job(n, ab, gap_next == 0);
        end
        bus.start_valid = 1'b0;
        bus.abort       = 1'b0;

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", evq.size(), 0);
        chk("total_reg_en", act_reg, exp_reg);
        chk("total_done", act_done, exp_done);
        chk("total_fresh_en", act_fresh, exp_fresh);
        chk("total_busy", act_busy, exp_busy);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
